demux_1to2_stream: RTL and testbench

- Distributes a single ready/valid word stream to one of two independent sink ports, selected per word.
- Each sink port has its own small FIFO, so a stalled sink does not block traffic already bound for the other sink.
- Used where one producer (e.g. a writeback or bus-response path) must fan out to two consumers.
- Per-port delivered-word counters are provided for debug.

---
 rtl/demux_1to2_stream_if.sv | 37 +++
 rtl/demux_1to2_stream.sv | 113 +++++++++++
 tb/tb_demux_1to2_stream.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1to2_stream_if.sv
// ---------------------------------------------------------------------------
// demux_1to2_stream_if
// Purpose : bundles the input stream and the two output streams of
//           demux_1to2_stream.
// Signals : in_valid/in_ready/in_sel/in_data    producer side
//           out0_valid/out0_ready/out0_data     sink 0
//           out1_valid/out1_ready/out1_data     sink 1
// Modports: slave  - the demux itself (consumes in_*, produces out*)
//           master - the environment (producer plus both sinks)
// Handshake: a word moves on a rising edge where valid and ready are both 1;
//           a producer holding valid may not retract its word, and valid/data
//           stay stable until that edge.
// ---------------------------------------------------------------------------
interface demux_1to2_stream_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux_1to2_stream.sv
// ---------------------------------------------------------------------------
// demux_1to2_stream
// Purpose : routes each accepted input word to one of two sink ports, each
//           backed by its own DEPTH-entry FIFO, so a stalled sink never blocks
//           words already bound for the other sink. Counts delivered words
//           per port for debug.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           s      - stream bundle (demux_1to2_stream_if.slave)
//           cnt0   - words popped on port 0 (wraps)
//           cnt1   - words popped on port 1 (wraps)
// ---------------------------------------------------------------------------
module demux_1to2_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_1to2_stream_if.slave     s,
    output logic [CNT_W-1:0]       cnt0,
    output logic [CNT_W-1:0]       cnt1
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [AW-1:0]    wr_ptr_q [2];
    logic [AW-1:0]    wr_ptr_d [2];
    logic [AW-1:0]    rd_ptr_q [2];
    logic [AW-1:0]    rd_ptr_d [2];
    // One extra bit so that DEPTH (full) is distinct from 0 (empty).
    logic [AW:0]      occ_q    [2];
    logic [AW:0]      occ_d    [2];
    logic [CNT_W-1:0] cnt_q    [2];
    logic [CNT_W-1:0] cnt_d    [2];

    logic [1:0] full;
    logic [1:0] out_valid;
    logic [1:0] push;
    logic [1:0] pop;
    logic       in_ready_w;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            full[p]      = (occ_q[p] == OCC_FULL);
            out_valid[p] = (occ_q[p] != '0);
        end
        // Depends only on the selection and FIFO state, never on in_valid.
        in_ready_w = s.in_sel ? !full[1] : !full[0];
        // in_valid gates both pushes, so an unknown in_sel while idle is harmless.
        push[0]    = s.in_valid && in_ready_w && !s.in_sel;
        push[1]    = s.in_valid && in_ready_w &&  s.in_sel;
        pop[0]     = out_valid[0] && s.out0_ready;
        pop[1]     = out_valid[1] && s.out1_ready;
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p];
            rd_ptr_d[p] = rd_ptr_q[p];
            occ_d[p]    = occ_q[p];
            cnt_d[p]    = cnt_q[p];
            // DEPTH is a power of two, so the natural AW-bit rollover is the wrap.
            if (push[p]) begin
                wr_ptr_d[p] = wr_ptr_q[p] + AW'(1);
            end
            if (pop[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + AW'(1);
                cnt_d[p]    = cnt_q[p] + CNT_W'(1);
            end
            if (push[p] && !pop[p]) begin
                occ_d[p] = occ_q[p] + (AW+1)'(1);
            end else if (!push[p] && pop[p]) begin
                occ_d[p] = occ_q[p] - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                occ_q[p]    <= '0;
                cnt_q[p]    <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[p][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                occ_q[p]    <= occ_d[p];
                cnt_q[p]    <= cnt_d[p];
                if (push[p]) begin
                    mem_q[p][wr_ptr_q[p]] <= s.in_data;
                end
            end
        end
    end

    // Head words come straight from storage: no path from in_data, and the
    // cleared storage makes the data outputs read 0 during reset.
    assign s.in_ready   = in_ready_w;
    assign s.out0_valid = out_valid[0];
    assign s.out1_valid = out_valid[1];
    assign s.out0_data  = mem_q[0][rd_ptr_q[0]];
    assign s.out1_data  = mem_q[1][rd_ptr_q[1]];
    assign cnt0         = cnt_q[0];
    assign cnt1         = cnt_q[1];
endmodule

// File: tb/tb_demux_1to2_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_1to2_stream
// Directed bench for demux_1to2_stream (WIDTH=32, DEPTH=2, CNT_W=4).
// Inputs change and outputs are sampled on the falling edge; the DUT updates
// on the rising edge.
// ---------------------------------------------------------------------------
module tb_demux_1to2_stream;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    int               checks;
    int               errors;

    demux_1to2_stream_if #(.WIDTH(WIDTH)) bus ();

    demux_1to2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus),
        .cnt0  (cnt0),
        .cnt1  (cnt1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
    endtask

    task automatic push_word(input logic sel, input logic [WIDTH-1:0] data);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b%b exp 00", bus.out0_valid, bus.out1_valid);
        end
        checks++;
        if (cnt0 !== 4'd0 || cnt1 !== 4'd0 || bus.out0_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got cnt0=%0d cnt1=%0d d0=%h exp 0 0 0", cnt0, cnt1, bus.out0_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        push_word(1'b0, 32'hDEADBEEF);
        checks++;
        if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_head got v=%b d=%h exp v=1 d=deadbeef", bus.out0_valid, bus.out0_data);
        end
        checks++;
        if (bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_other_port got %b exp 0", bus.out1_valid);
        end
        bus.out0_ready = 1'b1;
        tick();
        bus.out0_ready = 1'b0;
        checks++;
        if (cnt0 !== 4'd1 || bus.out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got cnt0=%0d v=%b exp cnt0=1 v=0", cnt0, bus.out0_valid);
        end
    endtask

    task automatic test_fill_stall();
        push_word(1'b0, 32'h11);
        push_word(1'b0, 32'h22);
        bus.in_sel = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_sel0 got %b exp 0", bus.in_ready);
        end
        bus.in_sel = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_sel1 got %b exp 1", bus.in_ready);
        end
        @(negedge clk);
        push_word(1'b1, 32'h33);
        checks++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h33) begin
            errors++;
            $display("FAIL bypass_head got v=%b d=%h exp v=1 d=33", bus.out1_valid, bus.out1_data);
        end
        bus.out1_ready = 1'b1;
        tick();
        bus.out1_ready = 1'b0;
        checks++;
        if (cnt1 !== 4'd1 || bus.out1_valid !== 1'b0 || bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h11) begin
            errors++;
            $display("FAIL bypass_pop got cnt1=%0d v1=%b v0=%b d0=%h exp 1 0 1 11",
                     cnt1, bus.out1_valid, bus.out0_valid, bus.out0_data);
        end
        // Pop 0x11 so port 0 holds exactly one word (0x22).
        bus.out0_ready = 1'b1;
        tick();
        bus.out0_ready = 1'b0;
        checks++;
        if (bus.out0_data !== 32'h22 || cnt0 !== 4'd2) begin
            errors++;
            $display("FAIL stall_order got d0=%h cnt0=%0d exp 22 2", bus.out0_data, cnt0);
        end
    endtask

    task automatic test_simultaneous();
        bus.in_valid   = 1'b1;
        bus.in_sel     = 1'b0;
        bus.in_data    = 32'hA5A5A5A5;
        bus.out0_ready = 1'b1;
        tick();
        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b0;
        #1;
        checks++;
        if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hA5A5A5A5 || cnt0 !== 4'd3) begin
            errors++;
            $display("FAIL pushpop_head got v=%b d=%h cnt0=%0d exp 1 a5a5a5a5 3",
                     bus.out0_valid, bus.out0_data, cnt0);
        end
        // Occupancy must still be 1, so port 0 is not full.
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_occ got in_ready=%b exp 1", bus.in_ready);
        end
        @(negedge clk);
        bus.out0_ready = 1'b1;
        tick();
        bus.out0_ready = 1'b0;
        checks++;
        if (bus.out0_valid !== 1'b0 || cnt0 !== 4'd4) begin
            errors++;
            $display("FAIL pushpop_drain got v=%b cnt0=%0d exp 0 4", bus.out0_valid, cnt0);
        end
    endtask

    task automatic test_order_wrap();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] exp_w;
        int next_in  = 1;
        int received = 0;
        int cycles   = 0;
        while (received < 8 && cycles < 200) begin
            bus.out1_ready = 1'($urandom_range(0, 1));
            bus.in_valid   = (next_in <= 8);
            bus.in_sel     = 1'b1;
            bus.in_data    = WIDTH'(next_in);
            #1;
            if (bus.out1_valid && bus.out1_ready) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (bus.out1_data !== exp_w) begin
                    errors++;
                    $display("FAIL order_data got %h exp %h", bus.out1_data, exp_w);
                end
                received++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(WIDTH'(next_in));
                next_in++;
            end
            tick();
            cycles++;
        end
        bus.in_valid   = 1'b0;
        bus.out1_ready = 1'b0;
        #1;
        checks++;
        if (received != 8 || exp_q.size() != 0 || bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_complete got received=%0d left=%0d v1=%b exp 8 0 0",
                     received, exp_q.size(), bus.out1_valid);
        end
        // One word was delivered on port 1 earlier, plus these eight.
        checks++;
        if (cnt1 !== 4'd9) begin
            errors++;
            $display("FAIL order_cnt1 got %0d exp 9", cnt1);
        end
    endtask

    task automatic test_async_reset();
        push_word(1'b0, 32'h100);
        push_word(1'b0, 32'h101);
        push_word(1'b1, 32'h200);
        push_word(1'b1, 32'h201);
        checks++;
        if (bus.out0_data !== 32'h100 || bus.out1_data !== 32'h200 || bus.out0_valid !== 1'b1) begin
            errors++;
            $display("FAIL prefill got d0=%h d1=%h v0=%b exp 100 200 1",
                     bus.out0_data, bus.out1_data, bus.out0_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 ||
            bus.out0_data !== 32'h0 || bus.out1_data !== 32'h0) begin
            errors++;
            $display("FAIL async_clear got v=%b%b d0=%h d1=%h exp 00 0 0",
                     bus.out0_valid, bus.out1_valid, bus.out0_data, bus.out1_data);
        end
        checks++;
        if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
            errors++;
            $display("FAIL async_cnt got cnt0=%0d cnt1=%0d exp 0 0", cnt0, cnt1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_word(1'b1, 32'h5);
        checks++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h5 || bus.out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_head got v1=%b d1=%h v0=%b exp 1 5 0",
                     bus.out1_valid, bus.out1_data, bus.out0_valid);
        end
        bus.out1_ready = 1'b1;
        tick();
        bus.out1_ready = 1'b0;
        checks++;
        if (cnt1 !== 4'd1 || bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pop got cnt1=%0d v1=%b exp 1 0", cnt1, bus.out1_valid);
        end
    endtask

    task automatic test_counter_wrap();
        int sent   = 0;
        int cycles = 0;
        bus.out0_ready = 1'b1;
        bus.in_sel     = 1'b0;
        while ((sent < 17 || bus.out0_valid) && cycles < 100) begin
            bus.in_valid = (sent < 17);
            bus.in_data  = WIDTH'(sent);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            cycles++;
        end
        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b0;
        #1;
        checks++;
        if (sent != 17 || bus.out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain got sent=%0d v0=%b exp 17 0", sent, bus.out0_valid);
        end
        // 17 pops on a 4-bit counter from 0.
        checks++;
        if (cnt0 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_cnt0 got %0d exp 1", cnt0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_single_word();
        test_fill_stall();
        test_simultaneous();
        test_order_wrap();
        test_async_reset();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
